// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus.
// The fetch unit is master; memory is slave.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns PC and instruction register.
// One memory read per fetch, with a timeout.
module instruction_fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic               pc_load,
  input  logic               pc_sel,
  input  logic [ADDR_W-1:0]  branch_offset,
  input  logic [ADDR_W-1:0]  branch_target,
  instruction_fetch_unit_if.master mem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  fetched_pc,
  output logic               fetch_busy,
  output logic               fetch_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [7:0] LAST_WAIT =
    8'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~ADDR_W'(3);

  state_t            state;
  state_t            state_n;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] rel_pc;
  logic [ADDR_W-1:0] abs_pc;
  logic              timeout;

  assign mem.mem_req  = (state == BUSY);
  assign mem.mem_addr = addr_q;
  assign fetch_busy   = (state == BUSY);

  assign rel_pc  = fetched_pc
                 + (branch_offset << 2);
  assign abs_pc  = branch_target & ALIGN_MASK;
  assign next_pc = pc_load
                 ? (pc_sel ? abs_pc : rel_pc)
                 : pc;

  // An ack on the final wait cycle wins.
  assign timeout = (wait_cnt == LAST_WAIT)
                 && !mem.mem_ack;

  // State register; reset abandons any fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (fetch_start) state_n = BUSY;
      end
      BUSY: begin
        if (mem.mem_ack) state_n = IDLE;
        else if (timeout) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // PC, address, IR and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      fetched_pc  <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_q      <= '0;
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pc_load) pc <= next_pc;
          if (fetch_start) begin
            addr_q   <= next_pc;
            wait_cnt <= '0;
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            instr       <= mem.mem_rdata;
            fetched_pc  <= addr_q;
            pc          <= addr_q + ADDR_W'(4);
            instr_valid <= 1'b1;
          end else if (timeout) begin
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector table,
// scoreboard, and hand-written corner sequences.
module tb_instruction_fetch_unit;

  localparam int AW = 64;
  localparam int IW = 32;

  typedef struct {
    logic          pl;
    logic          ps;
    logic [AW-1:0] off;
    logic [AW-1:0] tgt;
    int            lat;
    logic [AW-1:0] addr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] fpc;
    logic [IW-1:0] ins;
    logic [AW-1:0] npc;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_start = 1'b0;
  logic          pc_load = 1'b0;
  logic          pc_sel = 1'b0;
  logic [AW-1:0] branch_offset = '0;
  logic [AW-1:0] branch_target = '0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW-1:0] fetched_pc;
  logic          fetch_busy;
  logic          fetch_err;

  logic          ack_auto = 1'b0;
  logic          ack_force = 1'b0;
  logic [IW-1:0] rdata_v = '0;
  int            mem_lat = 0;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;
  exp_t sb[$];
  vec_t vt[8];

  instruction_fetch_unit_if #(
    .ADDR_W(AW), .INSTR_W(IW)
  ) bus ();

  assign bus.mem_ack   = ack_auto | ack_force;
  assign bus.mem_rdata = rdata_v;

  instruction_fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW),
    .RESET_PC(64'h0), .MAX_WAIT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fetch_start(fetch_start),
    .pc_load(pc_load),
    .pc_sel(pc_sel),
    .branch_offset(branch_offset),
    .branch_target(branch_target),
    .mem(bus),
    .instr(instr),
    .instr_valid(instr_valid),
    .pc(pc),
    .fetched_pc(fetched_pc),
    .fetch_busy(fetch_busy),
    .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  function automatic logic [IW-1:0] f32(
    input logic [AW-1:0] a);
    return a[31:0] ^ 32'h8B02_0020;
  endfunction

  task automatic chk(input string nm,
                     input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  // Memory model: acks after mem_lat wait cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (bus.mem_req && !ack_force) begin
        if (cnt >= mem_lat) begin
          ack_auto = 1'b1;
          rdata_v  = f32(bus.mem_addr);
        end else begin
          ack_auto = 1'b0;
          cnt++;
        end
      end else begin
        ack_auto = 1'b0;
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor on instr_valid.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && instr_valid) begin
      nvalid++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        chk("sb_instr", AW'(instr), AW'(e.ins));
        chk("sb_fetched_pc", fetched_pc, e.fpc);
        chk("sb_pc", pc, e.npc);
      end
    end
  end

  task automatic wait_valid(output int n);
    int k;
    n = 0;
    k = 0;
    while (!instr_valid && k < 64) begin
      if (bus.mem_req) n++;
      @(negedge clock);
      k++;
    end
    if (k >= 64) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout actual=0 expected=1");
    end
  endtask

  task automatic do_fetch(input vec_t v);
    int n;
    pc_load       = v.pl;
    pc_sel        = v.ps;
    branch_offset = v.off;
    branch_target = v.tgt;
    mem_lat       = v.lat;
    fetch_start   = 1'b1;
    sb.push_back('{v.addr, f32(v.addr),
                   v.addr + 64'd4});
    @(negedge clock);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    chk("req_high", AW'(bus.mem_req), 1);
    chk("busy_high", AW'(fetch_busy), 1);
    chk("req_addr", bus.mem_addr, v.addr);
    wait_valid(n);
    chk("req_cycles", AW'(n), AW'(v.lat + 1));
  endtask

  initial begin
    int n;
    int k;
    vt[0] = '{0, 0, 0, 0, 2, 64'h0};
    vt[1] = '{0, 0, 0, 0, 0, 64'h4};
    vt[2] = '{0, 0, 0, 0, 0, 64'h8};
    vt[3] = '{1, 1, 0, 64'h43, 1, 64'h40};
    vt[4] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFE,
              0, 0, 64'h38};
    vt[5] = '{1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF,
              0, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[6] = '{0, 0, 0, 0, 3, 64'h0};
    vt[7] = '{1, 0, 64'h10, 0, 0, 64'h40};

    repeat (2) @(negedge clock);
    chk("rst_req", AW'(bus.mem_req), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_fpc", fetched_pc, 0);
    chk("rst_instr", AW'(instr), 0);
    chk("rst_valid", AW'(instr_valid), 0);
    chk("rst_busy", AW'(fetch_busy), 0);
    chk("rst_err", AW'(fetch_err), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_fetch(vt[i]);
      if (i == 2) chk("pc_after_3", pc, 64'hC);
    end

    // Absolute load in IDLE, then BUSY ignores.
    pc_load = 1'b1;
    pc_sel = 1'b1;
    branch_target = 64'h1003;
    @(negedge clock);
    pc_load = 1'b0;
    chk("abs_load_pc", pc, 64'h1000);
    chk("abs_load_idle", AW'(bus.mem_req), 0);
    mem_lat = 4;
    sb.push_back('{64'h1000, f32(64'h1000),
                   64'h1004});
    fetch_start = 1'b1;
    @(negedge clock);
    fetch_start = 1'b0;
    @(negedge clock);
    pc_load = 1'b1;
    pc_sel = 1'b1;
    branch_target = 64'h2000;
    fetch_start = 1'b1;
    @(negedge clock);
    pc_load = 1'b0;
    fetch_start = 1'b0;
    chk("busy_pc_hold", pc, 64'h1000);
    chk("busy_addr_hold", bus.mem_addr,
        64'h1000);
    wait_valid(n);
    chk("busy_ld_pc", pc, 64'h1004);

    // Ack while IDLE must be ignored.
    @(negedge clock);
    chk("no_refetch", AW'(bus.mem_req), 0);
    ack_force = 1'b1;
    rdata_v = 32'hDEAD_BEEF;
    @(negedge clock);
    ack_force = 1'b0;
    chk("idle_ack_valid", AW'(instr_valid), 0);
    chk("idle_ack_instr", AW'(instr),
        AW'(f32(64'h1000)));

    // Ack in the last permitted wait cycle.
    do_fetch('{0, 0, 0, 0, 14, 64'h1004});
    chk("late_ack_err", AW'(fetch_err), 0);

    // Memory never acks: timeout.
    mem_lat = 255;
    fetch_start = 1'b1;
    @(negedge clock);
    fetch_start = 1'b0;
    n = 0;
    k = 0;
    while (bus.mem_req && k < 64) begin
      n++;
      @(negedge clock);
      k++;
    end
    chk("to_req_cycles", AW'(n), 15);
    chk("to_err", AW'(fetch_err), 1);
    chk("to_pc", pc, 64'h1008);
    chk("to_fpc", fetched_pc, 64'h1004);
    repeat (3) @(negedge clock);
    chk("to_err_sticky", AW'(fetch_err), 1);
    chk("to_nvalid", AW'(nvalid), 10);
    do_fetch('{0, 0, 0, 0, 0, 64'h1008});
    chk("err_after_ok", AW'(fetch_err), 1);

    // Reset in the middle of a fetch.
    mem_lat = 255;
    fetch_start = 1'b1;
    @(negedge clock);
    fetch_start = 1'b0;
    @(negedge clock);
    chk("pre_rst_req", AW'(bus.mem_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_req", AW'(bus.mem_req), 0);
    chk("async_busy", AW'(fetch_busy), 0);
    chk("async_pc", pc, 0);
    chk("async_err", AW'(fetch_err), 0);
    @(negedge clock);
    reset = 1'b0;
    ack_force = 1'b1;
    rdata_v = 32'h1234_5678;
    @(negedge clock);
    ack_force = 1'b0;
    chk("late_ack_valid", AW'(instr_valid), 0);
    chk("late_ack_instr", AW'(instr), 0);
    @(negedge clock);
    chk("total_valid", AW'(nvalid), 11);
    chk("sb_empty", AW'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the LEGv8 control unit in the multicycle ARM_64 core.
- Owns the program counter and the instruction register. Issues one instruction-memory read per fetch request and presents the fetched instruction to the decode logic, which builds the EX0..EX5 control words.
- The control unit asserts fetch_start while in its IF state, and pc_load when a branch resolves.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value after reset; must be 4-byte aligned.
- MAX_WAIT, 15, maximum cycles mem_req stays high without mem_ack before a fetch aborts; range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_start  in  1  request one fetch at the current PC.
- pc_load  in  1  update PC from pc_sel this cycle.
- pc_sel  in  1  0 = PC-relative: fetched_pc + (branch_offset<<2); 1 = absolute: branch_target.
- branch_offset  in  ADDR_W  signed word offset, already sign-extended.
- branch_target  in  ADDR_W  absolute target, e.g. for BR.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address; stable while mem_req is high.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  INSTR_W  read data.
- instr  out  INSTR_W  instruction register.
- instr_valid  out  1  one-cycle pulse when instr is updated.
- pc  out  ADDR_W  next fetch address.
- fetched_pc  out  ADDR_W  address of the instruction currently held in instr.
- fetch_busy  out  1  high while in BUSY.
- fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (async, asserted): state=IDLE; pc=RESET_PC; fetched_pc=0; instr=0; instr_valid=0; mem_req=0; mem_addr=0; fetch_busy=0; fetch_err=0; wait counter=0.
- Reset asserted mid-fetch abandons the transaction immediately; mem_req drops without waiting for a clock edge.
- Next-PC: next_pc = pc_load ? (pc_sel ? {branch_target[ADDR_W-1:2],2'b00} : fetched_pc + (branch_offset<<2)) : pc.
  - Arithmetic is modulo 2^ADDR_W; no overflow flag.
- FSM states: IDLE, BUSY.
- IDLE:
  - pc_load: pc <= next_pc at the edge.
  - fetch_start: mem_addr <= next_pc; mem_req <= 1; counter <= 0; state <= BUSY.
  - pc_load and fetch_start in the same cycle: the fetch uses the new PC (next_pc).
- BUSY:
  - fetch_start and pc_load are ignored; pc is unchanged.
  - mem_ack sampled high at edge m:
    - instr <= mem_rdata; fetched_pc <= mem_addr; pc <= mem_addr + 4.
    - mem_req <= 0; instr_valid = 1 for exactly the cycle after m; state <= IDLE.
  - No mem_ack: counter increments.
  - Counter reaches MAX_WAIT with no mem_ack: mem_req <= 0; fetch_err <= 1; state <= IDLE.
    - instr, fetched_pc and pc are unchanged; no instr_valid pulse.
  - mem_ack on the same edge the counter reaches MAX_WAIT: the ack wins and no error is set.
- Latency:
  - fetch_start at edge k gives mem_req high from k+1.
  - Zero-wait memory (ack during the first mem_req cycle) gives instr_valid in cycle k+2.
  - Back-to-back fetches: the earliest new fetch_start is the cycle instr_valid is high.
- mem_ack while IDLE is ignored.
- fetch_err clears only on reset. Fetches continue normally while it is set.
- fetch_busy is high exactly in the cycles mem_req is high.
- PC wrap: pc = 64'hFFFF_FFFF_FFFF_FFFC fetched gives pc = 0.

Test Plan:
- Reset, then fetch_start one cycle; memory acks after 2 wait cycles with 32'h8B020020 -> mem_addr=0; mem_req high 3 cycles; instr=32'h8B020020; instr_valid one pulse; fetched_pc=0; pc=4.
- Three back-to-back fetches with zero-wait memory -> mem_addr sequence 0, 4, 8; three instr_valid pulses; final pc=12.
- After fetch at 0x40: pc_load, pc_sel=0, branch_offset=-2 (all ones ...FE), with fetch_start in the same cycle -> mem_addr=0x38.
- pc_load, pc_sel=1, branch_target=0x1003 -> pc=0x1000. pc_load asserted during BUSY -> pc unchanged.
- Memory never acks, MAX_WAIT=15 -> mem_req drops after 15 cycles; fetch_err=1 and stays 1; no instr_valid; next fetch with ack succeeds and fetch_err remains 1.
- Reset asserted 1 cycle into a pending fetch -> mem_req=0 asynchronously; pc=RESET_PC; a late mem_ack after reset causes no instr_valid.
